// File: rtl/ysyx_22050854_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050854_pc_gen
// Function : Program-counter generator. Offers PC to fetch, waits for execute
//            to resolve the instruction, then selects next PC (seq/branch/jal/
//            jalr/trap). Optional macro PC_GEN_MISALIGN_CHK_EN halts on a
//            misaligned taken target.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22050854_pc_gen #(
   parameter int              PC_W      = 32,
   parameter int              XLEN      = 64,
   parameter logic [PC_W-1:0] RESET_VEC = PC_W'(32'h8000_0000),
   parameter int              ILEN      = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [2:0]      branch,
   input  logic            no_branch,
   input  logic            zero,
   input  logic            less,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] imm,
   input  logic            trap_valid,
   input  logic [PC_W-1:0] trap_vec,
   input  logic            fetch_ready,
   output logic [PC_W-1:0] pc,
   output logic            pc_valid,
   output logic [PC_W-1:0] next_pc,
   output logic            illegal,
   output logic            halted,
   output logic            misalign
);

   localparam logic [1:0] S_BOOT    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT_EX = 2'd2;
   localparam logic [1:0] S_HALT    = 2'd3;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic            r_illegal;

   logic [PC_W-1:0] w_seq_pc;
   logic [PC_W-1:0] w_br_pc;
   logic [PC_W-1:0] w_jalr_pc;
   logic [PC_W-1:0] w_target;
   logic            w_taken;
   logic            w_illegal_enc;
   logic            w_misalign_hit;
   logic            w_trap;
   logic            w_resolve;
   logic            w_stop;

   // Only the low PC_W bits of the operands participate in address math.
   generate
      if (XLEN > PC_W) begin : g_hi_unused
         logic unused_hi;
         assign unused_hi = ^{src1[XLEN-1:PC_W], imm[XLEN-1:PC_W]};
      end
   endgenerate

   assign w_seq_pc  = r_pc + PC_W'(ILEN);
   assign w_br_pc   = r_pc + imm[PC_W-1:0];
   assign w_jalr_pc = (src1[PC_W-1:0] + imm[PC_W-1:0]) & ~PC_W'(1);

   always_comb begin
      w_taken  = 1'b0;
      w_target = w_br_pc;
      case (branch)
         3'b001:  w_taken = 1'b1;
         3'b010: begin
            w_taken  = 1'b1;
            w_target = w_jalr_pc;
         end
         3'b100:  w_taken = zero;
         3'b101:  w_taken = ~zero;
         3'b110:  w_taken = less;
         3'b111:  w_taken = ~less;
         default: w_taken = 1'b0;
      endcase
   end

   assign w_illegal_enc = (branch == 3'b011) || ((branch == 3'b000) && !no_branch);
   assign next_pc       = w_illegal_enc ? r_pc : (w_taken ? w_target : w_seq_pc);

`ifdef PC_GEN_MISALIGN_CHK_EN
   assign w_misalign_hit = w_taken && (w_target[1:0] != 2'b00);
`else
   assign w_misalign_hit = 1'b0;
`endif

   // Trap outranks everything except the boot cycle.
   assign w_trap    = trap_valid && (r_state != S_BOOT);
   assign w_resolve = ex_valid && (r_state == S_WAIT_EX) && !w_trap;
   assign w_stop    = w_illegal_enc || w_misalign_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_BOOT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_trap) begin
         w_state_nxt = S_ISSUE;
      end else begin
         case (r_state)
            S_BOOT:    w_state_nxt = S_ISSUE;
            S_ISSUE:   if (fetch_ready) w_state_nxt = S_WAIT_EX;
            S_WAIT_EX: if (ex_valid)    w_state_nxt = w_stop ? S_HALT : S_ISSUE;
            default:   w_state_nxt = S_HALT;
         endcase
      end
   end

   always_comb begin
      pc_valid = 1'b0;
      halted   = 1'b0;
      case (r_state)
         S_ISSUE: pc_valid = 1'b1;
         S_HALT:  halted   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_VEC;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_resolve && w_illegal_enc;
         if (w_trap)
            r_pc <= trap_vec;
         else if (w_resolve && !w_stop)
            r_pc <= next_pc;
      end
   end

`ifdef PC_GEN_MISALIGN_CHK_EN
   logic r_misalign;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_misalign <= 1'b0;
      else     r_misalign <= w_resolve && !w_illegal_enc && w_misalign_hit;
   end
   assign misalign = r_misalign;
`else
   assign misalign = 1'b0;
`endif

   assign pc      = r_pc;
   assign illegal = r_illegal;

endmodule
`default_nettype wire
